// File: rtl/video_in_write.sv
// Camera capture: packs four pixels per word, queues words in a FIFO and writes
// frames to RAM in locked Wishbone bursts. Optional geometry check: VIDEO_IN_SIZE_CHECK_EN.
module video_in_write #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        enable,
  input  logic [31:0] frame_base,
  input  logic        pixel_valid,
  input  logic        line_valid,
  input  logic        frame_valid,
  input  logic [7:0]  pixel_in,
  output logic        interrupt,
  output logic        overflow,
  output logic        size_error,
  output logic        p_wb_STB_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_LOCK_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic        p_wb_ACK_I
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  if (((WIDTH % 4) != 0) || (HEIGHT < 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (FIFO_DEPTH < 2 * BURST_LEN)) begin : g_bad_params
    $error("video_in_write: illegal parameter combination");
  end

  // IDLE: wait for data/flush | BURST: locked write burst | DONE: frame interrupt
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t state_q, state_d;

  logic          fv_q, fv_d, lv_q, lv_d;
  logic          capture_q, capture_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   word_q, word_d;
  logic          push_pend_q, push_pend_d;
  logic [31:0]   push_data_q, push_data_d;
  logic          push_tag_q, push_tag_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic          tag_q, tag_d;
  logic          flush_req_q, flush_req_d;
  logic          flush_armed_q, flush_armed_d;
  logic          flush_tag_q, flush_tag_d;
  logic          overflow_q, overflow_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [64:0]   mem_q [FIFO_DEPTH];

  logic fv_rise, fv_fall, lv_fall;
  logic fifo_full, fifo_wr, fifo_rd;
  logic [64:0] head;
  logic head_is_flush, more_flush;

  assign fv_rise   = frame_valid & ~fv_q;
  assign fv_fall   = ~frame_valid & fv_q;
  assign lv_fall   = ~line_valid & lv_q;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign fifo_wr   = push_pend_q & ~fifo_full;

  // FIFO entries carry their own address and frame tag, so dropped words keep
  // later addresses aligned and a new frame cannot extend the previous flush.
  assign head          = mem_q[rd_ptr_q];
  assign head_is_flush = (count_q != '0) && (head[64] == flush_tag_q);
  assign more_flush    = (count_q > CW'(1)) && (mem_q[rd_ptr_q + AW'(1)][64] == flush_tag_q);

  always_comb begin
    fv_d          = frame_valid;
    lv_d          = line_valid;
    capture_d     = capture_q;
    lane_d        = lane_q;
    word_d        = word_q;
    push_pend_d   = 1'b0;
    push_data_d   = push_data_q;
    push_tag_d    = push_tag_q;
    wr_addr_d     = wr_addr_q;
    tag_d         = tag_q;
    flush_req_d   = flush_req_q;
    flush_armed_d = flush_armed_q;
    flush_tag_d   = flush_tag_q;
    overflow_d    = overflow_q;

    if (push_pend_q) begin
      wr_addr_d = wr_addr_q + 32'd4;
      if (fifo_full) overflow_d = 1'b1;
    end

    if (capture_q && line_valid && pixel_valid) begin
      case (lane_q)
        2'd0: word_d[7:0]   = pixel_in;
        2'd1: word_d[15:8]  = pixel_in;
        2'd2: word_d[23:16] = pixel_in;
        default: begin
          word_d      = '0;
          push_pend_d = 1'b1;
          push_data_d = {pixel_in, word_q[23:0]};
          push_tag_d  = tag_q;
        end
      endcase
      lane_d = lane_q + 2'd1;
    end

    if (lv_fall) begin
      lane_d = 2'd0;
      word_d = '0;
      if (capture_q && (lane_q != 2'd0)) begin
        push_pend_d = 1'b1;
        push_data_d = word_q;
        push_tag_d  = tag_q;
      end
    end

    // Flush only counts once the frame's last word has left the packer.
    if (flush_req_q && !flush_armed_q && !(push_pend_q && (push_tag_q == flush_tag_q)))
      flush_armed_d = 1'b1;
    if (state_q == DONE) begin
      flush_req_d   = 1'b0;
      flush_armed_d = 1'b0;
    end

    if (fv_fall && capture_q) begin
      capture_d     = 1'b0;
      flush_req_d   = 1'b1;
      flush_armed_d = 1'b0;
      flush_tag_d   = tag_q;
    end

    if (fv_rise && enable) begin
      capture_d  = 1'b1;
      wr_addr_d  = frame_base & 32'hFFFF_FFFC;
      overflow_d = 1'b0;
      tag_d      = ~tag_q;
      lane_d     = 2'd0;
      word_d     = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    fifo_rd     = 1'b0;
    interrupt   = 1'b0;
    p_wb_STB_O  = 1'b0;
    p_wb_CYC_O  = 1'b0;
    p_wb_LOCK_O = 1'b0;
    p_wb_WE_O   = 1'b0;
    p_wb_SEL_O  = 4'h0;
    p_wb_ADR_O  = '0;
    p_wb_DAT_O  = '0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (flush_armed_q)                        state_d = head_is_flush ? BURST : DONE;
        else if (count_q >= CW'(BURST_LEN))       state_d = BURST;
      end
      BURST: begin
        p_wb_STB_O  = 1'b1;
        p_wb_CYC_O  = 1'b1;
        p_wb_LOCK_O = 1'b1;
        p_wb_WE_O   = 1'b1;
        p_wb_SEL_O  = 4'hF;
        p_wb_ADR_O  = head[63:32];
        p_wb_DAT_O  = head[31:0];
        if (p_wb_ACK_I) begin
          fifo_rd = 1'b1;
          beat_d  = beat_q + BW'(1);
          if ((beat_q == BW'(BURST_LEN - 1)) || (flush_armed_q && !more_flush))
            state_d = IDLE;
        end
      end
      DONE: begin
        interrupt = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = fifo_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(fifo_wr) - CW'(fifo_rd);
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= {push_tag_q, wr_addr_q, push_data_q};
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      fv_q          <= 1'b0;
      lv_q          <= 1'b0;
      capture_q     <= 1'b0;
      lane_q        <= 2'd0;
      word_q        <= '0;
      push_pend_q   <= 1'b0;
      push_data_q   <= '0;
      push_tag_q    <= 1'b0;
      wr_addr_q     <= '0;
      tag_q         <= 1'b0;
      flush_req_q   <= 1'b0;
      flush_armed_q <= 1'b0;
      flush_tag_q   <= 1'b0;
      overflow_q    <= 1'b0;
      beat_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fv_q          <= fv_d;
      lv_q          <= lv_d;
      capture_q     <= capture_d;
      lane_q        <= lane_d;
      word_q        <= word_d;
      push_pend_q   <= push_pend_d;
      push_data_q   <= push_data_d;
      push_tag_q    <= push_tag_d;
      wr_addr_q     <= wr_addr_d;
      tag_q         <= tag_d;
      flush_req_q   <= flush_req_d;
      flush_armed_q <= flush_armed_d;
      flush_tag_q   <= flush_tag_d;
      overflow_q    <= overflow_d;
      beat_q        <= beat_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  assign overflow = overflow_q;

`ifdef VIDEO_IN_SIZE_CHECK_EN
  logic [15:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic        size_error_q, size_error_d;

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    size_error_d = size_error_q;
    if (capture_q && line_valid && pixel_valid) pix_cnt_d = pix_cnt_q + 16'd1;
    if (capture_q && lv_fall) begin
      if (pix_cnt_q != 16'(WIDTH)) size_error_d = 1'b1;
      pix_cnt_d  = '0;
      line_cnt_d = line_cnt_q + 16'd1;
    end
    // line_cnt_d already includes a line ending in the same cycle as the frame
    if (capture_q && fv_fall && (line_cnt_d != 16'(HEIGHT))) size_error_d = 1'b1;
    if (fv_rise && enable) begin
      pix_cnt_d    = '0;
      line_cnt_d   = '0;
      size_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      size_error_q <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      size_error_q <= size_error_d;
    end
  end

  assign size_error = size_error_q;
`else
  assign size_error = 1'b0;
`endif

endmodule

// File: tb/tb_video_in_write.sv
// Directed bench for video_in_write: a frame-level model predicts every Wishbone
// write, the interrupt count and the sticky flags; a negedge monitor compares.
module tb_video_in_write;
  localparam int W = 8;
  localparam int H = 2;
`ifdef VIDEO_IN_SIZE_CHECK_EN
  localparam bit SIZE_CHK = 1'b1;
`else
  localparam bit SIZE_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] frame_base = '0;
  logic        pixel_valid = 1'b0, line_valid = 1'b0, frame_valid = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic        interrupt, overflow, size_error;
  logic        p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O;
  logic [3:0]  p_wb_SEL_O;
  logic [31:0] p_wb_ADR_O, p_wb_DAT_O;
  logic        p_wb_ACK_I;
  logic        ack_en = 1'b1;

  assign p_wb_ACK_I = ack_en;

  video_in_write #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(16), .BURST_LEN(8)) dut (
    .clk(clk), .RST(RST), .enable(enable), .frame_base(frame_base),
    .pixel_valid(pixel_valid), .line_valid(line_valid), .frame_valid(frame_valid),
    .pixel_in(pixel_in), .interrupt(interrupt), .overflow(overflow), .size_error(size_error),
    .p_wb_STB_O(p_wb_STB_O), .p_wb_CYC_O(p_wb_CYC_O), .p_wb_LOCK_O(p_wb_LOCK_O),
    .p_wb_WE_O(p_wb_WE_O), .p_wb_SEL_O(p_wb_SEL_O), .p_wb_ADR_O(p_wb_ADR_O),
    .p_wb_DAT_O(p_wb_DAT_O), .p_wb_ACK_I(p_wb_ACK_I));

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t         exp_q[$];
  logic [63:0] obs_q[$];
  int n_cmp = 0, n_bad = 0;
  int irq_seen = 0, irq_exp = 0, cyc_seen = 0;
  logic irq_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (!RST) begin
      if (p_wb_CYC_O) begin
        cyc_seen++;
        check("wb_ctl", {p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O, p_wb_SEL_O}, 7'h7F);
        if (p_wb_ACK_I) begin
          obs_q.push_back({p_wb_ADR_O, p_wb_DAT_O});
          if (exp_q.size() == 0) begin
            check("unexpected_write", {p_wb_ADR_O, p_wb_DAT_O}, 64'd0);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wb_adr", p_wb_ADR_O, e.addr);
            check("wb_dat", p_wb_DAT_O, e.data);
          end
        end
      end
      if (interrupt) begin
        irq_seen++;
        check("irq_after_writes", exp_q.size(), 0);
        check("irq_one_cycle", irq_prev, 0);
      end
      irq_prev = interrupt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [31:0] base, input int nlines, input int len,
                           input logic [7:0] pix0, input bit en, input int drop_lo,
                           input int drop_hi, input int ack_hold, input bit late_en);
    int n, elapsed;
    logic [31:0] w, base_al;
    bit exp_ovf, exp_se;
    int cyc0;
    n = 0; exp_ovf = 0; cyc0 = cyc_seen;
    base_al = base & 32'hFFFF_FFFC;
    exp_se = SIZE_CHK && ((nlines != H) || (len != W));
    for (int l = 0; l < nlines; l++) begin
      for (int wi = 0; wi < (len + 3) / 4; wi++) begin
        w = '0;
        for (int b = 0; b < 4; b++)
          if (4 * wi + b < len) w[8*b +: 8] = 8'(int'(pix0) + l * len + 4 * wi + b);
        if (en) begin
          if (n >= drop_lo && n <= drop_hi) exp_ovf = 1;
          else exp_q.push_back({base_al + 32'(4 * n), w});
        end
        n++;
      end
    end
    ack_en = (ack_hold == 0);
    enable = en; frame_base = base; frame_valid = 1'b1;
    elapsed = 0;
    tick(); elapsed++;
    if (en) check("flags_clear_at_start", {overflow, size_error}, 2'b00);
    if (late_en) enable = 1'b1;
    for (int l = 0; l < nlines; l++) begin
      line_valid = 1'b1;
      for (int i = 0; i < len; i++) begin
        pixel_valid = 1'b1;
        pixel_in = 8'(int'(pix0) + l * len + i);
        tick(); elapsed++;
      end
      pixel_valid = 1'b0; line_valid = 1'b0;
      tick(); tick(); elapsed += 2;
    end
    frame_valid = 1'b0; enable = 1'b0;
    if (ack_hold > 0) begin
      while (elapsed < ack_hold) begin tick(); elapsed++; end
      check("overflow_while_stalled", overflow, exp_ovf);
      ack_en = 1'b1;
    end
    if (en) irq_exp++;
    for (int c = 0; c < 3000; c++) begin
      if (irq_seen == irq_exp && exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("writes_drained", exp_q.size(), 0);
    check("irq_count", irq_seen, irq_exp);
    if (!en) check("no_cycle_when_disabled", cyc_seen - cyc0, 0);
    if (en) check("overflow_end", overflow, exp_ovf);
    if (en) check("size_error_end", size_error, exp_se);
    exp_q.delete();
  endtask

  initial begin
    int irq0, cyc0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctl", {interrupt, overflow, size_error, p_wb_STB_O, p_wb_CYC_O,
                      p_wb_LOCK_O, p_wb_WE_O, p_wb_SEL_O}, 11'd0);
    check("rst_bus", {p_wb_ADR_O, p_wb_DAT_O}, 64'd0);
    tick(); RST = 1'b0;
    tick();

    // WIDTH=8 x HEIGHT=2 frame, pixels 0x00..0x0F
    obs_q.delete();
    run_frame(32'h1000, 2, 8, 8'h00, 1'b1, -1, -1, 0, 1'b0);
    check("t1_count", obs_q.size(), 4);
    check("t1_w0", obs_q[0], {32'h1000, 32'h03020100});
    check("t1_w1", obs_q[1], {32'h1004, 32'h07060504});
    check("t1_w2", obs_q[2], {32'h1008, 32'h0B0A0908});
    check("t1_w3", obs_q[3], {32'h100C, 32'h0F0E0D0C});

    // 6-pixel line: one full word plus a zero-padded partial
    obs_q.delete();
    run_frame(32'h5000, 1, 6, 8'hA1, 1'b1, -1, -1, 0, 1'b0);
    check("t2_count", obs_q.size(), 2);
    check("t2_w0", obs_q[0], {32'h5000, 32'hA4A3A2A1});
    check("t2_w1", obs_q[1], {32'h5004, 32'h0000A6A5});

    // enable low at frame start, raised mid-frame
    run_frame(32'h6000, 2, 8, 8'h40, 1'b0, -1, -1, 0, 1'b1);

    // ACK stalled 100 cycles, 80 pixels: words 17..20 dropped
    run_frame(32'h4000, 1, 80, 8'h10, 1'b1, 16, 19, 100, 1'b0);

    // Unaligned base near the top of memory: low bits ignored, address wraps
    obs_q.delete();
    run_frame(32'hFFFF_FFFB, 1, 12, 8'hC0, 1'b1, -1, -1, 0, 1'b0);
    check("wrap_addr", obs_q[2][63:32], 32'h0000_0000);

    // Reset in the middle of a stalled burst
    irq0 = irq_seen;
    ack_en = 1'b0; enable = 1'b1; frame_base = 32'h2000; frame_valid = 1'b1;
    tick(); tick();
    line_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pixel_valid = 1'b1; pixel_in = 8'(i); tick();
    end
    pixel_valid = 1'b0;
    @(posedge clk); #3;
    check("burst_before_rst", {p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O}, 3'b111);
    RST = 1'b1;
    #1;
    check("rst_async_drop", {p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, interrupt}, 4'b0000);
    line_valid = 1'b0; frame_valid = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1; RST = 1'b0; ack_en = 1'b1;
    cyc0 = cyc_seen;
    repeat (50) @(negedge clk);
    check("no_irq_after_rst", irq_seen, irq0);
    check("no_cycle_after_rst", cyc_seen, cyc0);

    // Clean frame at a new base after reset
    obs_q.delete();
    run_frame(32'h3000, 2, 8, 8'h80, 1'b1, -1, -1, 0, 1'b0);
    check("post_rst_w0", obs_q[0], {32'h3000, 32'h83828180});

    // Three lines where two are expected
    run_frame(32'h7000, 3, 8, 8'h20, 1'b1, -1, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/video_in_write.md
Name: video_in_write

Overview:
- Upstream producer of the frame buffer: video_in_write captures the incoming camera pixel stream and writes frames into RAM.
- The output path later reads the same RAM region back.
- Packs four 8-bit pixels per 32-bit word and buffers words in an internal FIFO.
- Drains the FIFO to RAM through a Wishbone master in fixed-length locked bursts, then signals frame completion by interrupt.

Parameters:
- WIDTH, 640, pixels per line; must be a multiple of 4.
- HEIGHT, 480, lines per frame.
- FIFO_DEPTH, 16, internal word FIFO depth; power of 2, at least 2*BURST_LEN.
- BURST_LEN, 8, words per Wishbone burst.

Ports:
- clk  in  1  system clock, 100 MHz
- RST  in  1  asynchronous, active-high reset
- enable  in  1  capture enable; sampled only at frame start
- frame_base  in  32  RAM byte address of the frame; latched at frame start; bits [1:0] ignored
- pixel_valid  in  1  single-cycle strobe qualifying pixel_in
- line_valid  in  1  line active
- frame_valid  in  1  frame active
- pixel_in  in  8  pixel data
- interrupt  out  1  one-cycle pulse when the last word of a frame is acknowledged
- overflow  out  1  sticky: a word was dropped in the current frame
- size_error  out  1  frame geometry mismatch (optional feature)
- p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O  out  1 each  Wishbone master controls
- p_wb_SEL_O  out  4  byte selects
- p_wb_ADR_O  out  32  write address
- p_wb_DAT_O  out  32  write data
- p_wb_ACK_I  in  1  slave acknowledge

Behaviour:
- Clocking/reset: single clock domain. RST is asynchronous and active-high. While RST is high, all outputs are 0, the FIFO is empty, and the FSM is in IDLE. Asserting RST mid-burst drops CYC/STB in the same cycle; no completion pulse is issued.
- Frame start: on a rising edge of frame_valid with enable=1:
  - latch {frame_base[31:2],2'b00} into the word address;
  - clear overflow and size_error;
  - set the capture flag.
  - With enable=0 the whole frame is ignored.
- Capture and packing (capture flag set):
  - Each pixel_valid with line_valid=1 loads pixel_in into byte lane k, k = 0..3 (pixel 0 in bits [7:0]).
  - On k=3 the word is pushed into the FIFO on the next cycle (1-cycle latency).
  - pixel_valid with line_valid=0 is ignored.
- Partial word: if line_valid falls with k≠0, the partial word is pushed zero-padded, p_wb_SEL_O=4'hF. The lane counter resets on every line_valid fall.
- FIFO full: a push while full drops the word and sets overflow. The address still advances by 4, so later data stays aligned.
- Frame end: on the falling edge of frame_valid, clear the capture flag and raise an internal flush request.
- Writer FSM:
  - IDLE -> BURST when FIFO count >= BURST_LEN, or when flush is pending and count > 0.
  - IDLE -> DONE when flush is pending and the FIFO is empty.
  - BURST:
    - CYC=LOCK=STB=WE=1, SEL=4'hF; ADR and DAT_O are the current address and FIFO head.
    - On ACK: pop the FIFO and add 4 to the address.
    - Exit after BURST_LEN acks, or when the FIFO empties during a flush; returns to IDLE.
    - STB stays high between beats; the new head is presented in the cycle after ACK.
  - DONE: interrupt=1 for exactly one cycle, clear flush, -> IDLE.
- Simultaneous events:
  - Push and pop in the same cycle keep the count unchanged.
  - A new frame start while the previous flush is pending is accepted. The previous frame completes its writes and interrupt first, and its addresses are unaffected.
- Addresses: 32-bit, wrap modulo 2^32 without error.

Optional Feature:
- Macro: VIDEO_IN_SIZE_CHECK_EN.
- When defined:
  - count pixels per line and lines per frame;
  - at each line end, a pixel count ≠ WIDTH sets size_error;
  - at frame end, a line count ≠ HEIGHT sets size_error;
  - size_error is sticky until the next frame start.
- When undefined: size_error is tied to 0 and no counters are synthesised.

Test Plan:
- Frame with WIDTH=8, HEIGHT=2, frame_base=0x1000, ACK always 1, pixels 0x00..0x0F -> four writes to 0x1000..0x100C with data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; one interrupt pulse after the 4th ACK.
- Line of 6 pixels 0xA1..0xA6 -> words 0xA4A3A2A1 and 0x0000A6A5; address advances by 8.
- ACK held low for 100 cycles with FIFO_DEPTH=16 and 80 pixels -> overflow=1 and words 17..20 dropped. After ACK resumes, addresses remain base+4*n for surviving words; overflow clears at the next frame start.
- enable=0 at frame_valid rise -> no Wishbone cycle, no interrupt; enable later rising mid-frame has no effect.
- RST pulse mid-burst -> CYC/STB/LOCK drop asynchronously, no interrupt; the next frame starts cleanly at its new frame_base.
- With VIDEO_IN_SIZE_CHECK_EN, a frame of 3 lines when HEIGHT=2 -> size_error=1 at frame end; without the macro -> size_error stays 0.
